// File: rtl/calc_sequencer_if.sv
// Keypad-to-sequencer bundle: key strobe/code in, display value, blanking and status out.
interface calc_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic              key_valid;
  logic [4:0]        key;
  logic [WIDTH-1:0]  disp;
  logic [DIGITS-1:0] disp_mask;
  logic              busy;
  logic              err;
  logic              key_drop;

  modport master (
    output key_valid, key,
    input  disp, disp_mask, busy, err, key_drop
  );

  modport slave (
    input  key_valid, key,
    output disp, disp_mask, busy, err, key_drop
  );
endinterface

// File: rtl/calc_sequencer.sv
// Hex calculator controller: operand entry, chained operators, and a shared
// add/sub datapath plus a WIDTH-cycle shift-add multiplier.
//
// state    | meaning
// ENTRY    | operand being typed, display shows cur
// OP_PEND  | operator latched, display shows acc
// EXEC     | multiply iterating, display shows acc, keys other than clear dropped
// SHOW_RES | '=' result on display, next digit starts a fresh calculation
module calc_sequencer #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  calc_sequencer_if.slave  bus
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int MW = $clog2(WIDTH);

  typedef enum logic [1:0] {ENTRY, OP_PEND, EXEC, SHOW_RES} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t             r_state;
  op_t                r_op;
  op_t                r_next_op;
  logic               r_eq_pend;
  logic [WIDTH-1:0]   r_cur;
  logic [WIDTH-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [MW-1:0]      r_mcount;
  logic               r_err;
  logic               r_drop;

  logic               w_digit;
  logic               w_eq;
  logic               w_bs;
  logic               w_opkey;
  logic               w_clear;
  logic               w_droppable;
  op_t                w_key_op;
  op_t                w_new_op;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_borrow;
  logic [WIDTH:0]     w_step;
  logic [2*WIDTH-1:0] w_prod_nx;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_disp;
  logic [DIGITS-1:0]  w_mask;

  assign w_digit     = bus.key_valid && !bus.key[4];
  assign w_eq        = bus.key_valid && (bus.key == 5'h10);
  assign w_bs        = bus.key_valid && (bus.key == 5'h11);
  assign w_opkey     = bus.key_valid && (bus.key >= 5'h12) && (bus.key <= 5'h14);
  assign w_clear     = bus.key_valid && (bus.key == 5'h15);
  assign w_droppable = bus.key_valid && (bus.key <= 5'h14);

  always_comb begin
    w_key_op = OP_NONE;
    case (bus.key)
      5'h12:   w_key_op = OP_ADD;
      5'h13:   w_key_op = OP_SUB;
      5'h14:   w_key_op = OP_MUL;
      default: w_key_op = OP_NONE;
    endcase
  end

  assign w_new_op  = w_eq ? OP_NONE : w_key_op;
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_cur};
  assign w_diff    = r_acc - r_cur;
  assign w_borrow  = r_acc < r_cur;
  assign w_shifted = {r_cur[WIDTH-5:0], bus.key[3:0]};

  // One shift-add step: multiplicand acc, multiplier in the low half of prod.
  assign w_step    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_acc} : '0);
  assign w_prod_nx = {w_step, r_prod[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ENTRY;
      r_op      <= OP_NONE;
      r_next_op <= OP_NONE;
      r_eq_pend <= 1'b0;
      r_cur     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcount  <= '0;
      r_err     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_clear) begin
        r_state <= ENTRY;
        r_op    <= OP_NONE;
        r_cur   <= '0;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end else if (r_state == EXEC) begin
        r_drop <= w_droppable;
        r_prod <= w_prod_nx;
        if (r_mcount == '0) begin
          r_acc   <= w_prod_nx[WIDTH-1:0];
          r_op    <= r_next_op;
          r_state <= r_eq_pend ? SHOW_RES : OP_PEND;
          if (|w_prod_nx[2*WIDTH-1:WIDTH]) r_err <= 1'b1;
        end else begin
          r_mcount <= r_mcount - 1'b1;
        end
      end else if (w_digit) begin
        if (r_state == ENTRY) begin
          if (r_cnt < CW'(DIGITS)) begin
            r_cur <= w_shifted;
            // Leading zeros do not count toward the digit limit.
            if ((r_cnt != '0) || (bus.key[3:0] != 4'h0)) r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cur   <= {{(WIDTH-4){1'b0}}, bus.key[3:0]};
          r_cnt   <= {{(CW-1){1'b0}}, |bus.key[3:0]};
          r_state <= ENTRY;
          if (r_state == SHOW_RES) r_op <= OP_NONE;
        end
      end else if (w_bs) begin
        if (r_state == ENTRY) begin
          r_cur <= r_cur >> 4;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
      end else if (w_opkey || w_eq) begin
        case (r_state)
          ENTRY: begin
            case (r_op)
              OP_MUL: begin
                r_next_op <= w_new_op;
                r_eq_pend <= w_eq;
                r_prod    <= {{WIDTH{1'b0}}, r_cur};
                r_mcount  <= MW'(WIDTH - 1);
                r_state   <= EXEC;
              end
              OP_ADD: begin
                r_acc   <= w_sum[WIDTH-1:0];
                r_op    <= w_new_op;
                r_state <= w_eq ? SHOW_RES : OP_PEND;
                if (w_sum[WIDTH]) r_err <= 1'b1;
              end
              OP_SUB: begin
                r_acc   <= w_diff;
                r_op    <= w_new_op;
                r_state <= w_eq ? SHOW_RES : OP_PEND;
                if (w_borrow) r_err <= 1'b1;
              end
              default: begin
                r_acc   <= r_cur;
                r_op    <= w_new_op;
                r_state <= w_eq ? SHOW_RES : OP_PEND;
              end
            endcase
          end
          OP_PEND: begin
            if (w_opkey) r_op <= w_new_op;
          end
          SHOW_RES: begin
            if (w_opkey) begin
              r_op    <= w_new_op;
              r_state <= OP_PEND;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_disp = (r_state == ENTRY) ? r_cur : r_acc;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_mask[i] = (i == 0) || (|(w_disp >> (4 * i)));
    end
  end

  assign bus.disp      = w_disp;
  assign bus.disp_mask = w_mask;
  assign bus.busy      = (r_state == EXEC);
  assign bus.err       = r_err;
  assign bus.key_drop  = r_drop;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-driven controller for the hex calculator. It accepts debounced 5-bit keycodes, manages operand entry, pending-operator and chained-operation state, and sequences a shared arithmetic datapath: add and subtract complete in one cycle, and multiply runs as a WIDTH-cycle iterative shift-add. It sits between the keypad scanner (key strobe already synchronized to clk) and the seven-segment decoders, driving the displayed value and the per-digit blanking mask.

## Interface
- WIDTH, 32: operand/result width in bits; must equal 4*DIGITS.
- DIGITS, 8: maximum hex digits that can be entered and displayed.

- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- key_valid  input  1  one-cycle pulse; key is valid in that cycle.
- key  input  5  keycode: 0x00–0x0F hex digit; 0x10 '='; 0x11 backspace; 0x12 '+'; 0x13 '-'; 0x14 '*'; 0x15 clear; 0x16–0x1F ignored (no state change, no drop pulse).
- disp  output  WIDTH  value to display.
- disp_mask  output  DIGITS  bit i lit iff i==0 or |disp[WIDTH-1:4i].
- busy  output  1  multiply in progress.
- err  output  1  sticky overflow/borrow flag.
- key_drop  output  1  one-cycle pulse when a key is discarded because busy.

## Operation
- Registers: cur (entry operand), acc (left operand/result), op (NONE/ADD/SUB/MUL), next_op, cnt (entered digit count, 0..DIGITS), prod (2*WIDTH), mcount.
- States: ENTRY (disp=cur), OP_PEND (disp=acc), EXEC (disp=acc, busy=1), SHOW_RES (disp=acc).
- Digit, in ENTRY: if cnt<DIGITS, cur <= {cur[WIDTH-5:0], d}; cnt increments only if cnt>0 or d≠0. If cnt==DIGITS, the digit is ignored.
- Digit, in OP_PEND or SHOW_RES: cur <= d, cnt <= (d≠0), go to ENTRY. From SHOW_RES this also sets op <= NONE.
- Backspace: ENTRY only. cur <= cur>>4; cnt decrements if >0. Ignored in other states.
- Operator, in ENTRY with op==NONE: acc <= cur, op <= new, go to OP_PEND.
- Operator, in ENTRY with op ADD/SUB: acc <= acc op cur, op <= new, go to OP_PEND.
- Operator, in ENTRY with op MUL: next_op <= new, go to EXEC. On completion, op <= next_op and go to OP_PEND.
- Operator, in OP_PEND: replaces op, with no computation.
- Operator, in SHOW_RES: op <= new, go to OP_PEND (acc keeps the result).
- '=' in ENTRY: same as an operator but with next state SHOW_RES and op <= NONE afterwards. With op==NONE, acc <= cur.
- '=' in OP_PEND or SHOW_RES: ignored.
- Clear: accepted in every state, including EXEC. It zeroes cur, acc, cnt, op and err, and goes to ENTRY.
- Any non-clear key while busy: dropped, and key_drop pulses.
- Arithmetic is modulo 2^WIDTH.
  - ADD sets err on carry out.
  - SUB sets err on borrow (acc<cur).
  - MUL: prod starts as {0, cur}. Each EXEC cycle adds acc into the upper half when prod[0]=1, then shifts prod right one bit. The result is prod[WIDTH-1:0]; err is set if the true product ≥ 2^WIDTH.
- err clears only on clear or reset.

## Timing
- Reset values: disp=0, disp_mask=1, busy=0, err=0, key_drop=0, state ENTRY, op NONE.
- A key is sampled at the posedge where key_valid=1. Its effect is visible on disp and err after that edge (1-cycle latency for entry, add and sub).
- MUL: busy rises the edge after the accepting key and stays high exactly WIDTH cycles. On the edge where busy falls, disp holds the product and err is updated.
- key_drop is high for the cycle following the dropped key.
- A clear during EXEC deasserts busy on the next edge; no result is written.
- Reset asserted mid-EXEC immediately forces all reset values.

## Test plan
- Keys 0,1,2,3 → disp=0x123, disp_mask=0x07. Then backspace → disp=0x12, mask=0x03.
- Nine digits 1..9 → disp=0x12345678, the ninth digit is ignored, mask=0xFF.
- 5 + 3 = → disp=8, err=0. Then 3 - 5 = → disp=0xFFFFFFFE, err=1. Then clear → disp=0, err=0.
- 1234 * 10 = → busy high 32 cycles, then disp=0x12340, err=0. FFFFFFFF * 2 = → disp=0xFFFFFFFE, err=1.
- 2 + 3 + 4 = → disp=5 after the second '+', disp=9 after '='.
- 3 * 4 = then key '7' while busy → key_drop pulses, final disp=0xC. Separately, clear at EXEC cycle 10 → busy=0 next cycle, disp=0.
